mpu_int_scale: RTL

MPU_INT_SCALE -- requirements
Module: mpu_int_scale

---
 rtl/mpu_int_scale.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mpu_int_scale.sv
// mpu_int_scale: multiplies every element of a signed DIM x DIM matrix by a
// signed scalar, LANES elements per cycle, with saturate or wrap reduction
// back to WIDTH bits and a sticky overflow flag for the operation.
//
// Handshake: a request is taken on a rising edge where start=1 and ready=1;
// ready is high only in IDLE, and start seen in any other state is dropped
// (never queued). done is a one-cycle pulse meaning result/overflow are
// complete; both then hold until the next accepted request.
module mpu_int_scale #(
   parameter int WIDTH       = 8,
   parameter int DIM         = 5,
   parameter int LANES       = 5,
   parameter int SAT_DEFAULT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       saturate,
   input  logic [WIDTH-1:0]           factor,
   input  logic [WIDTH*DIM*DIM-1:0]   matrix_a,
   output logic                       ready,
   output logic                       done,
   output logic                       overflow,
   output logic [WIDTH*DIM*DIM-1:0]   result,
   output logic [1:0]                 state_dbg
);

   localparam int N     = DIM * DIM;
   localparam int BEATS = (N + LANES - 1) / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Signed WIDTH range expressed at full product width.
   localparam logic signed [2*WIDTH-1:0] MAX_P = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] MIN_P = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]          MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]          MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   logic [BW-1:0]          beat;
   logic [WIDTH*N-1:0]     a_q;
   logic [WIDTH-1:0]       factor_q;
   logic                   sat_q;

   int                         lane_idx  [LANES];
   logic                       lane_ok   [LANES];
   logic signed [WIDTH-1:0]    lane_elem [LANES];
   logic signed [2*WIDTH-1:0]  lane_prod [LANES];
   logic                       lane_ovf  [LANES];
   logic [WIDTH-1:0]           lane_val  [LANES];
   logic                       any_ovf;

   assign ready     = (state == IDLE);
   assign state_dbg = state;

   // Per-lane datapath for the current beat: fetch, full-width multiply, reduce.
   always_comb begin
      any_ovf = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         lane_idx[l]  = int'(beat) * LANES + l;
         lane_ok[l]   = (lane_idx[l] < N);
         // Lanes past the last element read element 0 and are discarded.
         lane_elem[l] = a_q[(lane_ok[l] ? lane_idx[l] : 0) * WIDTH +: WIDTH];
         lane_prod[l] = $signed({{WIDTH{lane_elem[l][WIDTH-1]}}, lane_elem[l]}) *
                        $signed({{WIDTH{factor_q[WIDTH-1]}}, factor_q});
         lane_ovf[l]  = lane_ok[l] && ((lane_prod[l] > MAX_P) || (lane_prod[l] < MIN_P));
         if (lane_ovf[l] && sat_q)
            lane_val[l] = lane_prod[l][2*WIDTH-1] ? MIN_W : MAX_W;
         else
            lane_val[l] = lane_prod[l][WIDTH-1:0];
         any_ovf = any_ovf | lane_ovf[l];
      end
   end

   // Control FSM plus operand capture, in-place result writes and overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat     <= '0;
         a_q      <= '0;
         factor_q <= '0;
         sat_q    <= (SAT_DEFAULT != 0);
         done     <= 1'b0;
         overflow <= 1'b0;
         result   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q      <= matrix_a;
                  factor_q <= factor;
                  sat_q    <= saturate;
                  overflow <= 1'b0;
                  beat     <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  if (lane_ok[l])
                     result[lane_idx[l]*WIDTH +: WIDTH] <= lane_val[l];
               end
               if (any_ovf)
                  overflow <= 1'b1;
               if (beat == BW'(BEATS - 1)) begin
                  beat  <= '0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
